neg_sub_arbiter: RTL and testbench
==================================

# neg_sub_arbiter

Sequencer and arbiter for the shared 32-bit two's-complement negation unit in the processor datapath. Two requesters (ALU SUB path, NEG instruction path) issue NEG or SUB operations over valid/ready handshakes. The block grants one requester round-robin, steps the single negator and an adder through a small FSM, and returns a registered result with signed-overflow flag and requester ID.

## Interface
- WIDTH, 32, operand/result width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  1  0 = NEG (result = -a), 1 = SUB (result = a - b)
- req0_a  in  WIDTH  operand a
- req0_b  in  WIDTH  operand b (ignored for NEG)
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester index that owns the result
- rsp_data  out  WIDTH  result
- rsp_ovf  out  1  signed overflow of the result

## Operation
- One clock (clk); reset is asynchronous and active-low (rst_n).
- States: IDLE, NEG, ADD, RESP.
- IDLE: if any reqN_valid, pick grantee, assert its reqN_ready combinationally, latch op, a, b, id; go to NEG. Otherwise stay.
- Arbitration: round-robin on last_grant. Only one valid -> that one wins. Both valid -> requester != last_grant wins. last_grant updates on accept. Reset value of last_grant = 1, so requester 0 wins the first tie.
- req0_ready and req1_ready never both high; both low outside IDLE.
- NEG: shared unit computes tmp = ~x + 1 (x = a for NEG, b for SUB), registered. NEG op -> result = tmp, go to RESP. SUB op -> go to ADD.
- ADD: result = a + tmp, modulo 2^WIDTH, go to RESP.
- RESP: rsp_valid = 1; rsp_data, rsp_id, rsp_ovf held stable until rsp_ready = 1; on handshake go to IDLE.
- Overflow: NEG -> rsp_ovf = 1 iff a = 0x8000_0000 (result 0x8000_0000). SUB -> rsp_ovf = 1 iff sign(a) != sign(b) and sign(result) != sign(a). The intermediate negation overflow for b = 0x8000_0000 is not reported separately; the sign rule covers it.
- Requester operands may change after accept; latched copies are used.

## Timing
- Reset (async assert, sync-free deassert): state = IDLE, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_ovf = 0, last_grant = 1, internal regs = 0. Both reqN_ready = 0 while rst_n low.
- Reset mid-operation aborts the operation. No response is produced. The accepted request is lost.
- Accept at cycle T (IDLE). NEG: rsp_valid at T+2. SUB: rsp_valid at T+3.
- rsp_ready high on first RESP cycle -> IDLE at next edge. Next accept no earlier than that IDLE cycle. Peak throughput: one NEG per 3 cycles, one SUB per 4 cycles.
- rsp_ready ignored outside RESP. Requests arriving outside IDLE wait; valid must be held by the requester until ready.
- Outputs rsp_* are registered; reqN_ready is combinational from state, last_grant and reqN_valid.

## Test plan
- Reset then req0 NEG a=0x0000_0005, rsp_ready=1 -> req0_ready at T, rsp_valid at T+2, rsp_data=0xFFFF_FFFB, rsp_id=0, rsp_ovf=0.
- req1 SUB a=0x0000_000A b=0x0000_0003 -> rsp_valid at T+3, rsp_data=0x0000_0007, rsp_id=1; SUB a=0 b=0x8000_0000 -> rsp_data=0x8000_0000, rsp_ovf=1; NEG a=0x8000_0000 -> 0x8000_0000, ovf=1; NEG a=0 -> 0, ovf=0.
- Both valid continuously with NEG ops after reset -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; never both readys high.
- Hold rsp_ready=0 for 5 cycles in RESP, change req operands -> rsp_valid, rsp_data, rsp_id stable; no new accept until the handshake.
- Assert rst_n=0 during ADD of a SUB -> rsp_valid=0 immediately, state IDLE; after release, next tie goes to requester 0.

Source files
------------

// File: rtl/neg_sub_arbiter.sv
// Round-robin arbiter and sequencer for the shared two's-complement negator.
// Two requesters issue NEG (-a) or SUB (a - b); the result is returned with its owner ID and a signed-overflow flag.
module neg_sub_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NEG,
    S_ADD,
    S_RESP
  } state_t;

  localparam logic             OP_NEG  = 1'b0;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_last_grant;
  logic             r_op;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_tmp;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_ovf;

  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_neg_in;
  logic [WIDTH-1:0] w_neg;
  logic [WIDTH-1:0] w_sum;
  logic             w_neg_ovf;
  logic             w_sub_ovf;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Ready is gated by rst_n so neither requester sees an accept while reset is held.
  assign w_accept   = rst_n && (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept &&  w_grant;

  // The single negator serves operand a for NEG and operand b for SUB.
  assign w_neg_in  = (r_op == OP_NEG) ? r_a : r_b;
  assign w_neg     = ~w_neg_in + ONE;
  assign w_sum     = r_a + r_tmp;
  assign w_neg_ovf = (r_a == MIN_NEG);
  assign w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_op         <= 1'b0;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_tmp        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op         <= w_grant ? req1_op : req0_op;
            r_a          <= w_grant ? req1_a  : req0_a;
            r_b          <= w_grant ? req1_b  : req0_b;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= S_NEG;
          end
        end
        S_NEG: begin
          r_tmp <= w_neg;
          if (r_op == OP_NEG) begin
            r_rsp_data  <= w_neg;
            r_rsp_ovf   <= w_neg_ovf;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_rsp_data  <= w_sum;
          r_rsp_ovf   <= w_sub_ovf;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_neg_sub_arbiter.sv
// Directed bench for neg_sub_arbiter: latency, results, overflow, round-robin, back-pressure and mid-op reset.
module tb_neg_sub_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;
  int both_hi  = 0;

  neg_sub_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op   (req0_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op   (req1_op),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (req0_ready && req1_ready) both_hi++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic id, input logic op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Waits from the cycle after accept until rsp_valid; returns cycles since accept.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called at posedge+1 in IDLE; leaves at posedge+1 back in IDLE.
  task automatic do_op(input string tag, input logic id, input logic op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input logic exp_ovf);
    int lat;
    drive(id, op, a, b);
    #1;
    check({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    check({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF; req0_b = 32'h1234_5678; req1_b = 32'h1234_5678;
    wait_rsp(lat);
    check({tag, "_lat"}, lat, op ? 3 : 2);
    check({tag, "_data"}, rsp_data, exp_d);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_ovf"}, rsp_ovf, exp_ovf);
    @(posedge clk); #1;
    check({tag, "_done"}, rsp_valid, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    req0_valid = 1'b1; req0_op = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b1;
    #12;
    check("rst_valid", rsp_valid, 0);
    check("rst_data",  rsp_data, 0);
    check("rst_id",    rsp_id, 0);
    check("rst_ovf",   rsp_ovf, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("neg5",    1'b0, 1'b0, 32'h0000_0005, 32'h0,         32'hFFFF_FFFB, 1'b0);
    do_op("sub10_3", 1'b1, 1'b1, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b0);
    do_op("sub0_min",1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1);
    do_op("neg_min", 1'b0, 1'b0, 32'h8000_0000, 32'h0,         32'h8000_0000, 1'b1);
    do_op("neg0",    1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0);
    do_op("sub_povf",1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    do_op("sub_neg", 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FFE0, 1'b0);

    // Round-robin with both requesters continuously valid after reset.
    pulse_reset();
    drive(1'b0, 1'b0, 32'h0000_0001, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_0002, 32'h0);
    for (int k = 0; k < 4; k++) begin
      logic g;
      g = k[0];
      #1;
      check($sformatf("rr%0d_ready0", k), req0_ready, !g);
      check($sformatf("rr%0d_ready1", k), req1_ready, g);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check($sformatf("rr%0d_valid", k), rsp_valid, 1);
      check($sformatf("rr%0d_id", k), rsp_id, g);
      check($sformatf("rr%0d_data", k), rsp_data, g ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Back-pressure: result must hold while rsp_ready is low; no accept meanwhile.
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 32'd100, 32'd30);
    #1;
    check("bp_ready0", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(lat);
    check("bp_lat", lat, 3);
    req0_a = 32'h5555_5555; req0_b = 32'hAAAA_AAAA;
    drive(1'b1, 1'b0, 32'd7, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d_valid", i), rsp_valid, 1);
      check($sformatf("bp%0d_data", i), rsp_data, 32'd70);
      check($sformatf("bp%0d_id", i), rsp_id, 0);
      check($sformatf("bp%0d_ready1", i), req1_ready, 0);
      req0_a = req0_a + 32'd1;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_ready1", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp(lat);
    check("bp_next_lat", lat, 2);
    check("bp_next_data", rsp_data, 32'hFFFF_FFF9);
    check("bp_next_id", rsp_id, 1);
    @(posedge clk); #1;

    // Reset during ADD of a SUB granted to requester 0.
    drive(1'b0, 1'b1, 32'd50, 32'd20);
    #1;
    check("rs_ready0", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd3, 32'h0);
    drive(1'b1, 1'b0, 32'd4, 32'h0);
    #1;
    check("rs_valid", rsp_valid, 0);
    check("rs_data", rsp_data, 0);
    check("rs_ready0_low", req0_ready, 0);
    check("rs_ready1_low", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rs_tie_ready0", req0_ready, 1);
    check("rs_tie_ready1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(lat);
    check("rs_next_lat", lat, 2);
    check("rs_next_data", rsp_data, 32'hFFFF_FFFD);
    check("rs_next_id", rsp_id, 0);
    @(posedge clk); #1;

    check("both_ready_never", both_hi, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
